conv_result_collector: RTL

CONV_RESULT_COLLECTOR -- requirements
Module: conv_result_collector

---
 rtl/hss_pkg.sv | 12 +
 rtl/conv_result_collector_if.sv | 27 ++
 rtl/pingpong_ram.sv | 28 ++
 rtl/conv_result_collector.sv | 88 ++++++++
 4 files changed

// File: rtl/hss_pkg.sv
// hss_pkg: shared defaults and bank-state encoding for the result collector.
// Exports: DEF_DATA_WIDTH, DEF_FRAME_LEN, DEF_ADDR_WIDTH, bank_state_e.
package hss_pkg;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAME_LEN  = 64;
    localparam int DEF_ADDR_WIDTH = 6;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        FULL  = 2'd2
    } bank_state_e;
endpackage

// File: rtl/conv_result_collector_if.sv
// conv_result_collector_if: sample input, CPU read and frame handshake signals.
// master = convolution/CPU side (drives samples, reads, ack); slave = collector.
interface conv_result_collector_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_parity;
    logic                  in_we;
    logic                  rd_en;
    logic                  rd_bank;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  ack;
    logic                  frame_ready;
    logic                  frame_bank;
    logic                  overflow;
    modport master (
        output in_data, in_parity, in_we, rd_en, rd_bank, rd_addr, ack,
        input  rd_data, rd_valid, frame_ready, frame_bank, overflow
    );
    modport slave (
        input  in_data, in_parity, in_we, rd_en, rd_bank, rd_addr, ack,
        output rd_data, rd_valid, frame_ready, frame_bank, overflow
    );
endinterface

// File: rtl/pingpong_ram.sv
// pingpong_ram: two-bank sample store, one write port, one registered read port.
// Ports: clk; we_i/wbank_i/waddr_i/wdata_i write; re_i/rbank_i/raddr_i read; rdata_o holds last read.
module pingpong_ram
    import hss_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  wbank_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic                  rbank_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [2][FRAME_LEN];
    logic [DATA_WIDTH-1:0] rdata_q;
    // Read and write share one edge, so a colliding read returns the old word.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[wbank_i][waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[rbank_i][raddr_i];
    end
    assign rdata_o = rdata_q;
endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: ping-pong frame collector for convolution results with CPU readback.
// Ports: clk, rst (async, active-high); bus (slave) carries samples, reads and frame handshake.
module conv_result_collector
    import hss_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FRAME_LEN  = DEF_FRAME_LEN,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    conv_result_collector_if.slave bus
);
    bank_state_e           state_q [2];
    bank_state_e           state_d [2];
    logic [ADDR_WIDTH-1:0] wr_ptr_q [2];
    logic [ADDR_WIDTH-1:0] wr_ptr_d [2];
    logic                  frame_ready_q, frame_ready_d;
    logic                  frame_bank_q, frame_bank_d;
    logic                  overflow_q, overflow_d;
    logic                  rd_valid_q;
    logic                  rd_seen_q;
    logic                  acc, done, ack_fire;
    logic [DATA_WIDTH-1:0] ram_rdata;
    always_comb begin
        acc      = bus.in_we && (state_q[bus.in_parity] != FULL);
        done     = acc && (wr_ptr_q[bus.in_parity] == ADDR_WIDTH'(FRAME_LEN - 1));
        ack_fire = bus.ack && frame_ready_q;
        for (int b = 0; b < 2; b++) begin
            state_d[b]  = state_q[b];
            wr_ptr_d[b] = wr_ptr_q[b];
            if (ack_fire && frame_bank_q == 1'(b)) state_d[b] = EMPTY;
            if (acc && bus.in_parity == 1'(b)) begin
                state_d[b]  = done ? FULL : FILL;
                wr_ptr_d[b] = done ? '0 : wr_ptr_q[b] + ADDR_WIDTH'(1);
            end else if (acc && state_q[b] == FILL) begin
                // Producer switched parity mid-frame: the partial frame is abandoned.
                state_d[b]  = EMPTY;
                wr_ptr_d[b] = '0;
            end
        end
        frame_ready_d = (state_d[0] == FULL) || (state_d[1] == FULL);
        // With both banks full the bank already being shown is the older frame.
        frame_bank_d  = (state_d[0] == FULL && state_d[1] == FULL) ? frame_bank_q
                                                                    : (state_d[1] == FULL);
        overflow_d    = overflow_q || (bus.in_we && !acc);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= '{EMPTY, EMPTY};
            wr_ptr_q      <= '{'0, '0};
            frame_ready_q <= 1'b0;
            frame_bank_q  <= 1'b0;
            overflow_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_seen_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            frame_ready_q <= frame_ready_d;
            frame_bank_q  <= frame_bank_d;
            overflow_q    <= overflow_d;
            rd_valid_q    <= bus.rd_en;
            rd_seen_q     <= rd_seen_q || bus.rd_en;
        end
    end
    pingpong_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (acc),
        .wbank_i(bus.in_parity),
        .waddr_i(wr_ptr_q[bus.in_parity]),
        .wdata_i(bus.in_data),
        .re_i   (bus.rd_en),
        .rbank_i(bus.rd_bank),
        .raddr_i(bus.rd_addr),
        .rdata_o(ram_rdata)
    );
    // The RAM read register has no reset; rd_data reads as zero until the first read after reset.
    assign bus.rd_data     = rd_seen_q ? ram_rdata : '0;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.frame_bank  = frame_bank_q;
    assign bus.overflow    = overflow_q;
endmodule
